// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder (DVI 1.0) with running-disparity DC balance.
// Stage 1 builds the transition-minimised word q_m. Stage 2 picks the
// DC-balanced symbol and updates the disparity counter. An optional third
// register stage eases timing into the DDR serialiser.
// SYMBOL_MODE "RESTRICTED" keeps the old 5-ones colour-bar subset. In that
// mode the disparity counter stays at zero.
module tmds_channel_encoder #(
  parameter string SYMBOL_MODE = "FULL",
  parameter int    OUT_REG     = 1
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic       de_i,
  input  logic [7:0] data_i,
  input  logic [1:0] ctrl_i,
  output logic [9:0] sym_o,
  output logic       de_o,
  output logic [4:0] disp_o
);

  localparam bit FULL_MODE = (SYMBOL_MODE == "FULL");
  localparam int STAGES    = (OUT_REG != 0) ? 3 : 2;

  localparam logic [9:0] SYM_CTRL00 = 10'b1101010100;
  localparam logic [9:0] SYM_CTRL01 = 10'b0010101011;
  localparam logic [9:0] SYM_CTRL10 = 10'b0101010100;
  localparam logic [9:0] SYM_CTRL11 = 10'b1010101011;
  localparam logic [9:0] SYM_RES_HI = 10'b1011110000;
  localparam logic [9:0] SYM_RES_LO = 10'b0111110000;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // de travels alongside the symbol as a shift register; [1] is stage 1.
  logic [STAGES:1] de_pipe_q;

  // stage 1 state
  logic [3:0] n1d;
  logic       use_xnor;
  logic       qm_acc;
  logic [7:0] qm_chain;
  logic [8:0] qm_d, qm1_q;
  logic [1:0] ctrl1_q;

  // stage 2 state
  logic [3:0] n1q;
  logic [4:0] diff;   // n1q - n0q, two's complement
  logic       qm8;
  logic [9:0] sym_d, sym2_q;
  logic [4:0] cnt_d, cnt_q;

  // Shift de through the pipeline so de_o lines up with sym_o.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) de_pipe_q <= '0;
    else        de_pipe_q <= {de_pipe_q[STAGES-1:1], de_i};
  end

  // Stage 1 comb: choose XOR/XNOR chain to minimise transitions.
  // RESTRICTED mode only needs data[7]. It rides in bit 7 of the q_m register.
  always_comb begin
    n1d      = popcnt8(data_i);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_i[0]);
    qm_acc   = data_i[0];
    qm_chain = '0;
    qm_chain[0] = qm_acc;
    for (int i = 1; i < 8; i++) begin
      qm_acc      = use_xnor ? ~(qm_acc ^ data_i[i]) : (qm_acc ^ data_i[i]);
      qm_chain[i] = qm_acc;
    end
    if (FULL_MODE) qm_d = {~use_xnor, qm_chain};
    else           qm_d = {1'b0, data_i[7], 7'b0};
  end

  // Stage 1 registers: q_m and control bits.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      qm1_q   <= '0;
      ctrl1_q <= '0;
    end else begin
      qm1_q   <= qm_d;
      ctrl1_q <= ctrl_i;
    end
  end

  // Stage 2 comb: DC-balance selection and disparity update.
  // The counter uses modular 5-bit arithmetic. Legal streams stay well inside
  // the signed range, so no saturation is needed.
  always_comb begin
    n1q   = popcnt8(qm1_q[7:0]);
    diff  = {n1q, 1'b0} - 5'd8;
    qm8   = qm1_q[8];
    sym_d = SYM_CTRL00;
    cnt_d = '0;
    if (!de_pipe_q[1]) begin
      // Blanking always restarts the disparity from zero.
      unique case (ctrl1_q)
        2'b00:   sym_d = SYM_CTRL00;
        2'b01:   sym_d = SYM_CTRL01;
        2'b10:   sym_d = SYM_CTRL10;
        default: sym_d = SYM_CTRL11;
      endcase
    end else if (!FULL_MODE) begin
      sym_d = qm1_q[7] ? SYM_RES_HI : SYM_RES_LO;
    end else if ((cnt_q == 5'd0) || (n1q == 4'd4)) begin
      sym_d = {~qm8, qm8, qm8 ? qm1_q[7:0] : ~qm1_q[7:0]};
      cnt_d = qm8 ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((!cnt_q[4] && (n1q > 4'd4)) || (cnt_q[4] && (n1q < 4'd4))) begin
      // Disparity would grow: send the inverted word.
      sym_d = {1'b1, qm8, ~qm1_q[7:0]};
      cnt_d = cnt_q + {3'b000, qm8, 1'b0} - diff;
    end else begin
      sym_d = {1'b0, qm8, qm1_q[7:0]};
      cnt_d = cnt_q - {3'b000, ~qm8, 1'b0} + diff;
    end
  end

  // Stage 2 registers: symbol and running disparity.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sym2_q <= SYM_CTRL00;
      cnt_q  <= '0;
    end else begin
      sym2_q <= sym_d;
      cnt_q  <= cnt_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [9:0] sym3_q;
    logic [4:0] disp3_q;

    // Optional retiming stage in front of the serialiser.
    always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
        sym3_q  <= SYM_CTRL00;
        disp3_q <= '0;
      end else begin
        sym3_q  <= sym2_q;
        disp3_q <= cnt_q;
      end
    end

    assign sym_o  = sym3_q;
    assign disp_o = disp3_q;
  end else begin : g_no_out_reg
    assign sym_o  = sym2_q;
    assign disp_o = cnt_q;
  end

  assign de_o = de_pipe_q[STAGES];

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder. It drives three instances from the same
// inputs: FULL with latency 2, FULL with latency 3, and RESTRICTED with
// latency 2. Every cycle it compares their outputs with a behavioural TMDS
// model, and it adds hand-computed directed checks.
module tb_tmds_channel_encoder;

  logic       clk_pix = 1'b0;
  logic       rst_n   = 1'b0;
  logic       de_i    = 1'b0;
  logic [7:0] data_i  = '0;
  logic [1:0] ctrl_i  = '0;

  logic [9:0] sym0, sym1, symr;
  logic       de0, de1, der;
  logic [4:0] disp0, disp1, dispr;

  int checks = 0;
  int errors = 0;

  always #5 clk_pix = ~clk_pix;

  tmds_channel_encoder #(.SYMBOL_MODE("FULL"), .OUT_REG(0)) u_f0 (
    .clk_pix(clk_pix), .rst_n(rst_n), .de_i(de_i), .data_i(data_i),
    .ctrl_i(ctrl_i), .sym_o(sym0), .de_o(de0), .disp_o(disp0));

  tmds_channel_encoder #(.SYMBOL_MODE("FULL"), .OUT_REG(1)) u_f1 (
    .clk_pix(clk_pix), .rst_n(rst_n), .de_i(de_i), .data_i(data_i),
    .ctrl_i(ctrl_i), .sym_o(sym1), .de_o(de1), .disp_o(disp1));

  tmds_channel_encoder #(.SYMBOL_MODE("RESTRICTED"), .OUT_REG(0)) u_r (
    .clk_pix(clk_pix), .rst_n(rst_n), .de_i(de_i), .data_i(data_i),
    .ctrl_i(ctrl_i), .sym_o(symr), .de_o(der), .disp_o(dispr));

  // Expected output per input cycle, indexed by the edge that sampled it.
  logic [9:0] h_sym  [0:2047];
  int         h_disp [0:2047];
  logic       h_de   [0:2047];
  logic [9:0] h_rsym [0:2047];
  int t    = 0;
  int mcnt = 0;
  int acc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Behavioural DVI encoder in integer arithmetic.
  task automatic model_full(input logic de, input logic [7:0] d, input logic [1:0] c,
                            output logic [9:0] s);
    logic [8:0] q;
    int n1d, n1, n0;
    if (!de) begin
      mcnt = 0;
      s = ctrl_sym(c);
    end else begin
      n1d  = $countones(d);
      q    = '0;
      q[0] = d[0];
      if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
        for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
        q[8] = 1'b0;
      end else begin
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
        q[8] = 1'b1;
      end
      n1 = $countones(q[7:0]);
      n0 = 8 - n1;
      if (mcnt == 0 || n1 == n0) begin
        s = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
        mcnt = mcnt + (q[8] ? (n1 - n0) : (n0 - n1));
      end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
        s = {1'b1, q[8], ~q[7:0]};
        mcnt = mcnt + 2 * int'(q[8]) + (n0 - n1);
      end else begin
        s = {1'b0, q[8], q[7:0]};
        mcnt = mcnt - 2 * (q[8] ? 0 : 1) + (n1 - n0);
      end
    end
  endtask

  // One clock with given inputs; compare every instance against history.
  task automatic step(input logic de, input logic [7:0] d, input logic [1:0] c);
    logic [9:0] s;
    de_i = de; data_i = d; ctrl_i = c;
    model_full(de, d, c, s);
    h_sym[t]  = s;
    h_disp[t] = mcnt;
    h_de[t]   = de;
    h_rsym[t] = !de ? ctrl_sym(c) : (d[7] ? 10'b1011110000 : 10'b0111110000);
    @(posedge clk_pix); #1;
    chk("f0_sym",  32'(sym0), 32'(h_sym[t-1]));
    chk("f0_disp", int'($signed(disp0)), h_disp[t-1]);
    chk("f0_de",   32'(de0), 32'(h_de[t-1]));
    chk("f1_sym",  32'(sym1), 32'(h_sym[t-2]));
    chk("f1_disp", int'($signed(disp1)), h_disp[t-2]);
    chk("f1_de",   32'(de1), 32'(h_de[t-2]));
    chk("r_sym",   32'(symr), 32'(h_rsym[t-1]));
    chk("r_de",    32'(der), 32'(h_de[t-1]));
    chk("r_disp",  32'(dispr), 32'h0);
    if (de0) acc = acc + 2 * $countones(sym0) - 10;
    else     acc = 0;
    t++;
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    mcnt  = 0;
    for (int k = 0; k < n; k++) begin
      h_sym[t] = 10'h354; h_disp[t] = 0; h_de[t] = 1'b0; h_rsym[t] = 10'h354;
      @(posedge clk_pix); #1;
      chk("rst_f0_sym",  32'(sym0), 32'h354);
      chk("rst_f0_disp", 32'(disp0), 32'h0);
      chk("rst_f0_de",   32'(de0), 32'h0);
      chk("rst_f1_sym",  32'(sym1), 32'h354);
      chk("rst_f1_de",   32'(de1), 32'h0);
      chk("rst_r_sym",   32'(symr), 32'h354);
      t++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held low, then released away from the clock edge.
    reset_cycles(3);
    #1;
    chk("rel_f0_sym", 32'(sym0), 32'h354);
    step(1'b0, 8'h00, 2'b00);
    chk("idle_f0_sym", 32'(sym0), 32'h354);
    step(1'b0, 8'h00, 2'b00);

    // Control symbols in consecutive cycles.
    step(1'b0, 8'h00, 2'b01);
    step(1'b0, 8'h00, 2'b10);
    chk("ctrl01", 32'(sym0), 32'h0AB);
    step(1'b0, 8'h00, 2'b11);
    chk("ctrl10", 32'(sym0), 32'h154);
    step(1'b1, 8'h00, 2'b00);
    chk("ctrl11", 32'(sym0), 32'h2AB);
    chk("ctrl_disp", 32'(disp0), 32'h0);
    chk("ctrl10_f1", 32'(sym1), 32'h154);

    // Two 0x00 pixels after blanking.
    step(1'b1, 8'h00, 2'b00);
    chk("zero1_sym",  32'(sym0), 32'h100);
    chk("zero1_disp", int'($signed(disp0)), -8);
    step(1'b0, 8'h00, 2'b00);
    chk("zero2_sym",  32'(sym0), 32'h3FF);
    chk("zero2_disp", int'($signed(disp0)), 2);
    chk("zero1_f1_sym",  32'(sym1), 32'h100);
    chk("zero1_f1_disp", int'($signed(disp1)), -8);
    chk("zero1_f1_de",   32'(de1), 32'h1);
    step(1'b0, 8'h00, 2'b00);
    chk("blank_disp", 32'(disp0), 32'h0);
    chk("zero2_f1_sym", 32'(sym1), 32'h3FF);

    // Restricted subset.
    step(1'b1, 8'h80, 2'b00);
    step(1'b1, 8'h7F, 2'b00);
    chk("res_80", 32'(symr), 32'h2F0);
    step(1'b0, 8'h00, 2'b00);
    chk("res_7f", 32'(symr), 32'h1F0);
    chk("res_disp", 32'(dispr), 32'h0);

    // Long random active run; model compared each cycle in step().
    step(1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 1000; i++) step(1'b1, 8'($urandom), 2'b00);
    step(1'b0, 8'h00, 2'b00);
    chk("run_balance", 32'(acc), int'($signed(disp0)));
    step(1'b0, 8'h00, 2'b00);
    chk("run_blank_disp", 32'(disp0), 32'h0);

    // First active pixel after blanking restarts from cnt=0.
    step(1'b1, 8'hFF, 2'b00);
    step(1'b0, 8'h00, 2'b00);
    chk("ff_first_sym",  32'(sym0), 32'h200);
    chk("ff_first_disp", int'($signed(disp0)), -8);

    // Reset in the middle of an active run, then resume.
    step(1'b1, 8'h00, 2'b00);
    step(1'b1, 8'h55, 2'b00);
    reset_cycles(2);
    step(1'b1, 8'h00, 2'b00);
    step(1'b0, 8'h00, 2'b00);
    chk("resume_sym",  32'(sym0), 32'h100);
    chk("resume_disp", int'($signed(disp0)), -8);
    step(1'b0, 8'h00, 2'b00);
    chk("resume_f1_sym", 32'(sym1), 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
